pipelined_mac_frame: RTL
========================

// Module: pipelined_mac_frame
// PURPOSE
//  Parametrised, pipelined multiply-accumulate engine that computes framed dot products.
//  A start pulse arms a frame of LEN samples. Operand pairs are accepted on a valid/ready
//  handshake, then registered, multiplied and accumulated. The frame result and an
//  overflow flag are presented with a one-cycle valid pulse.
//  Sits between operand sources (FIFO/streams) and result consumers; next generation of
//  the fixed 4-bit MAC.
// PARAMETERS
//  DATA_W    8   operand width (in1, in2)
//  ACC_W     18  accumulator/result width; must satisfy ACC_W >= 2*DATA_W
//  LEN_W     8   width of frame-length input
//  SIGNED    0   1: two's-complement operands and accumulator; 0: unsigned
//  SATURATE  1   1: clamp on overflow; 0: wrap modulo 2^ACC_W
// PORTS
//  clock      in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high; clears all state
//  start      in   1       arm a new frame (honoured only in IDLE)
//  len        in   LEN_W   sample count of the frame, sampled with start
//  in_valid   in   1       operand pair valid
//  in_ready   out  1       engine accepts a pair this cycle (comb: state==RUN)
//  in1, in2   in   DATA_W  operands
//  out        out  ACC_W   frame result, held until the next frame completes
//  out_ovf    out  1       frame saw overflow/wrap, held with out
//  out_valid  out  1       one-cycle pulse: out/out_ovf updated
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, acc=0, out=0, out_ovf=0, out_valid=0, all stage valids=0, counter=0.
//  FSM:
//   - IDLE -start&len!=0-> RUN: acc=0, ovf=0, remaining=len.
//   - IDLE -start&len==0-> DRAIN: acc=0, ovf=0.
//   - RUN: accept = in_valid & in_ready. Each accept decrements remaining.
//     An accept with remaining==1 moves to DRAIN.
//   - DRAIN: on the first edge where s1_valid==0 and p_valid==0: out<=acc,
//     out_ovf<=ovf, out_valid<=1, go to IDLE.
//   - start outside IDLE is ignored.
//   - start is legal in the cycle out_valid is high (state is already IDLE).
//  Pipeline (stage valid bits travel with data; bubbles allowed at any point):
//   - S1: on an accept edge, a<=in1, b<=in2, s1_valid<=1; else s1_valid<=0.
//   - S2: p<=a*b (2*DATA_W, signed if SIGNED), p_valid<=s1_valid.
//   - S3: if p_valid, acc<=f(acc + ext(p)); ext is sign- or zero-extension to ACC_W.
//  Latency: last accept on edge E; acc final at E+2; out_valid high after edge E+3.
//   len==0 gives out_valid on the edge after the start edge, out=0.
//  Overflow:
//   - Compute the sum in ACC_W+1 bits.
//   - Unsigned overflow = carry out. Signed overflow = operand signs equal and result sign differs.
//   - SATURATE=1: clamp to 2^ACC_W-1 (unsigned), or 2^(ACC_W-1)-1 / -2^(ACC_W-1) (signed).
//     Once saturated, later terms continue from the clamped value.
//   - SATURATE=0: wrap.
//   - Either mode sets sticky ovf for the frame.
//  out_valid is low except for the single completion cycle. out/out_ovf hold otherwise.
//  in_valid with in_ready=0 is ignored (no accept, no state change).
//  Reset mid-frame aborts immediately: no out_valid, out returns to 0.
// TESTING
//  T1 (defaults) start, len=3; pairs (2,3),(4,5),(1,1) back-to-back
//     -> out=27, ovf=0, out_valid exactly 3 edges after last accept.
//  T2 same as T1 with in_valid gaps of 0-3 cycles and in_valid asserted in IDLE/DRAIN
//     -> out=27, exactly 3 accepts, in_ready low outside RUN.
//  T3 len=8, all pairs (255,255), SATURATE=1 -> out=262143, out_ovf=1.
//     With SATURATE=0 -> out=258056, out_ovf=1.
//  T4 SIGNED=1, len=2, pairs (-3,4),(2,-5) -> out=-22 (18'h3FFEA), ovf=0.
//     Signed saturation at -131072 checked.
//  T5 start with len=0 -> out=0, out_valid on the next edge.
//     start during RUN is ignored (frame result unchanged).
//  T6 reset asserted after 2 of 5 accepts -> all outputs 0 at once, no out_valid.
//     A new frame after reset produces the correct result.

Source files
------------

// File: rtl/pipelined_mac_frame.sv
// rtl/pipelined_mac_frame.sv - framed, pipelined multiply-accumulate engine with sticky overflow
module pipelined_mac_frame #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 18,
    parameter int LEN_W    = 8,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic [ACC_W-1:0]  out,
    output logic              out_ovf,
    output logic              out_valid,
    output logic              busy
);

    localparam int PW = 2 * DATA_W;
    localparam bit IS_SIGNED = (SIGNED != 0);
    localparam bit IS_SAT = (SATURATE != 0);
    localparam logic [ACC_W-1:0] U_MAX = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [LEN_W-1:0]  remaining;
    logic [DATA_W-1:0] a, b;
    logic              s1_valid;
    logic [PW-1:0]     p;
    logic              p_valid;
    logic [ACC_W-1:0]  acc;
    logic              ovf;

    logic              accept, frame_arm, drain_done;
    logic [PW-1:0]     a_x, b_x, prod;
    logic [ACC_W-1:0]  p_ext, sat_val, acc_nx;
    logic [ACC_W:0]    sum_w;
    logic              term_ovf;

    assign in_ready   = (state == RUN);
    assign busy       = (state != IDLE);
    assign accept     = in_valid && in_ready;
    assign frame_arm  = (state == IDLE) && start;
    assign drain_done = (state == DRAIN) && !s1_valid && !p_valid;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (len != '0) ? RUN : DRAIN;
            RUN:     if (accept && remaining == LEN_W'(1)) state_nx = DRAIN;
            DRAIN:   if (!s1_valid && !p_valid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Operands are extended to the full product width, so one truncated multiply serves both modes.
    assign a_x  = {{DATA_W{IS_SIGNED && a[DATA_W-1]}}, a};
    assign b_x  = {{DATA_W{IS_SIGNED && b[DATA_W-1]}}, b};
    assign prod = a_x * b_x;

    assign p_ext = ACC_W'(p) | ((IS_SIGNED && p[PW-1]) ? ({ACC_W{1'b1}} << PW) : '0);
    assign sum_w = {1'b0, acc} + {1'b0, p_ext};

    always_comb begin
        term_ovf = 1'b0;
        sat_val  = U_MAX;
        if (IS_SIGNED) begin
            term_ovf = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (sum_w[ACC_W-1] != acc[ACC_W-1]);
            sat_val  = acc[ACC_W-1] ? S_MIN : S_MAX;
        end else begin
            term_ovf = sum_w[ACC_W];
        end
        acc_nx = (term_ovf && IS_SAT) ? sat_val : sum_w[ACC_W-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            a         <= '0;
            b         <= '0;
            s1_valid  <= 1'b0;
            p         <= '0;
            p_valid   <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
            out       <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (frame_arm)   remaining <= len;
            else if (accept) remaining <= remaining - LEN_W'(1);

            s1_valid <= accept;
            if (accept) begin
                a <= in1;
                b <= in2;
            end

            p       <= prod;
            p_valid <= s1_valid;

            if (frame_arm) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (p_valid) begin
                acc <= acc_nx;
                ovf <= ovf | term_ovf;
            end

            out_valid <= drain_done;
            if (drain_done) begin
                out     <= acc;
                out_ovf <= ovf;
            end
        end
    end

endmodule
